des_round_wrapper: RTL and testbench



---
 rtl/des_pkg.sv | 62 ++++++
 rtl/des_f_function.sv | 37 +++
 rtl/des_round_wrapper.sv | 54 +++++
 tb/tb_des_round_wrapper.sv | 135 +++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES types and standard tables (E, P, S-boxes) used by the round datapath.
// Table entries use DES 1-based, MSB-first bit numbering.
package des_pkg;

    typedef logic [31:0] half_t;
    typedef logic [47:0] subkey_t;

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is indexed by row*16 + col.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

endpackage

// File: rtl/des_f_function.sv
// Combinational DES round function f(R, K): expansion, key mix, S-boxes, permutation P.
module des_f_function
    import des_pkg::*;
(
    input  half_t   in_right,
    input  subkey_t round_key,
    output half_t   f
);

    subkey_t     expanded;
    subkey_t     mixed;
    half_t       sbox_out;
    logic [5:0]  grp;

    always_comb begin
        expanded = '0;
        mixed    = '0;
        sbox_out = '0;
        grp      = '0;
        f        = '0;

        // Table position n (1-based, MSB first) maps to vector bit width-n.
        for (int i = 0; i < 48; i++)
            expanded[47-i] = in_right[32-E_TABLE[i]];

        mixed = expanded ^ round_key;

        for (int s = 0; s < 8; s++) begin
            grp = mixed[47-6*s -: 6];
            sbox_out[31-4*s -: 4] = SBOX[s][{grp[5], grp[0], grp[4:1]}];
        end

        for (int i = 0; i < 32; i++)
            f[31-i] = sbox_out[32-P_TABLE[i]];
    end

endmodule

// File: rtl/des_round_wrapper.sv
// Registered single DES Feistel round, one-cycle latency.
// Define DES_ROUND_VALID_EN to add in_valid/out_valid and gate register loads.
module des_round_wrapper
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
`ifdef DES_ROUND_VALID_EN
    input  logic        in_valid,
`endif
    input  logic [31:0] in_left,
    input  logic [31:0] in_right,
    input  logic [47:0] round_key,
    output logic [31:0] out_left,
`ifdef DES_ROUND_VALID_EN
    output logic [31:0] out_right,
    output logic        out_valid
`else
    output logic [31:0] out_right
`endif
);

    half_t f;
    logic  load;

    des_f_function u_f (
        .in_right  (in_right),
        .round_key (round_key),
        .f         (f)
    );

`ifdef DES_ROUND_VALID_EN
    assign load = in_valid;

    always_ff @(posedge clk) begin
        if (!n_rst) out_valid <= 1'b0;
        else        out_valid <= in_valid;
    end
`else
    assign load = 1'b1;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_left  <= '0;
            out_right <= '0;
        end else if (load) begin
            out_left  <= in_right;
            out_right <= in_left ^ f;
        end
    end

endmodule

// File: tb/tb_des_round_wrapper.sv
// Directed scoreboard bench for des_round_wrapper, using known-answer DES round vectors.
module tb_des_round_wrapper;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic [47:0] round_key;
    logic [31:0] out_left;
    logic [31:0] out_right;
`ifdef DES_ROUND_VALID_EN
    logic        in_valid;
    logic        out_valid;
`endif

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    des_round_wrapper dut (
        .clk       (clk),
        .n_rst     (n_rst),
`ifdef DES_ROUND_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .in_left   (in_left),
        .in_right  (in_right),
        .round_key (round_key),
        .out_left  (out_left),
        .out_right (out_right)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic step(input string tag, input logic rst_n, input logic v,
                        input logic [31:0] l, input logic [31:0] r, input logic [47:0] k,
                        input logic [31:0] el, input logic [31:0] er);
        exp_t e;
        @(negedge clk);
        n_rst     = rst_n;
        in_left   = l;
        in_right  = r;
        round_key = k;
`ifdef DES_ROUND_VALID_EN
        in_valid  = v;
`endif
        sb.push_back('{l: el, r: er, v: rst_n & v});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_left"},  out_left,  e.l);
            check({tag, "_right"}, out_right, e.r);
`ifdef DES_ROUND_VALID_EN
            check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, e.v});
`endif
        end
    endtask

    initial begin
        n_rst     = 1'b0;
        in_left   = 32'hA5A5_5A5A;
        in_right  = 32'h1234_5678;
        round_key = 48'hDEAD_BEEF_CAFE;
`ifdef DES_ROUND_VALID_EN
        in_valid  = 1'b1;
`endif

        step("rst_a", 1'b0, 1'b1, 32'hA5A5_5A5A, 32'h1234_5678, 48'hDEAD_BEEF_CAFE, 32'h0, 32'h0);
        step("rst_b", 1'b0, 1'b1, 32'h0F0F_F0F0, 32'h8765_4321, 48'h1111_2222_3333, 32'h0, 32'h0);

        // Back-to-back known-answer vectors, one per cycle.
        step("zero",    1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 48'h0,              32'h0000_0000, 32'hD8D8_DBBC);
        step("k_ones",  1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 48'hFFFF_FFFF_FFFF, 32'h0000_0000, 32'h38DB_F9CB);
        step("lr_ones", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'h0,              32'hFFFF_FFFF, 32'hC724_0634);
        step("all_one", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'h2727_2443);
        step("r_ones",  1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 48'h0,              32'hFFFF_FFFF, 32'h38DB_F9CB);
        step("l_ones",  1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 48'h0,              32'h0000_0000, 32'h2727_2443);

        // First two rounds of the classic worked DES example (key 133457799BBCDFF1).
        step("round1",  1'b1, 1'b1, 32'hCC00_CCFF, 32'hF0AA_F0AA, 48'h1B02_EFFC_7072, 32'hF0AA_F0AA, 32'hEF4A_6544);
        step("round2",  1'b1, 1'b1, 32'hF0AA_F0AA, 32'hEF4A_6544, 48'h79AE_D9DB_C9E5, 32'hEF4A_6544, 32'hCC01_7709);

        step("mid_rst", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF, 32'h0, 32'h0);
        step("resume",  1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 48'h0,              32'h0000_0000, 32'hD8D8_DBBC);

        // Inputs wiggling between edges must not disturb the registered outputs.
        #2;
        in_left   = 32'h1357_9BDF;
        in_right  = 32'h2468_ACE0;
        round_key = 48'h0123_4567_89AB;
        #1;
        check("midcyc_left",  out_left,  32'h0000_0000);
        check("midcyc_right", out_right, 32'hD8D8_DBBC);

`ifdef DES_ROUND_VALID_EN
        step("hold_a",  1'b1, 1'b0, 32'hCC00_CCFF, 32'hF0AA_F0AA, 48'h1B02_EFFC_7072, 32'h0000_0000, 32'hD8D8_DBBC);
        step("hold_b",  1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 48'h0,              32'h0000_0000, 32'hD8D8_DBBC);
        step("load",    1'b1, 1'b1, 32'hCC00_CCFF, 32'hF0AA_F0AA, 48'h1B02_EFFC_7072, 32'hF0AA_F0AA, 32'hEF4A_6544);
        step("hold_c",  1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 48'h0,              32'hF0AA_F0AA, 32'hEF4A_6544);
        step("load_2",  1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 48'h0,              32'h0000_0000, 32'h2727_2443);
`endif

        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
